axi4_lite_master_bridge: RTL and testbench

//   Upstream AXI4-Lite master for the GPIO peripheral (and any other AXI4-Lite slave).

---
 rtl/axi4_lite_master_bridge_if.sv | 50 +++++
 rtl/axi4_lite_master_bridge.sv | 177 +++++++++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master_bridge_if
// Description : AXI4-Lite channel bundle (AW/W/B/AR/R) between the bridge
//               master and an AXI4-Lite slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4_lite_master_bridge_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   // Write address channel
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   // Write data channel
   logic [DATA_WIDTH-1:0] WDATA;
   logic                  WVALID;
   logic                  WREADY;
   // Write response channel
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   // Read address channel
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   // Read data channel
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output AWADDR, AWVALID, input AWREADY,
      output WDATA, WVALID, input WREADY,
      input BRESP, BVALID, output BREADY,
      output ARADDR, ARVALID, input ARREADY,
      input RDATA, RRESP, RVALID, output RREADY
   );

   modport slave (
      input AWADDR, AWVALID, output AWREADY,
      input WDATA, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input ARADDR, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input RREADY
   );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_master_bridge
// Description : Converts single-word CPU requests (transfer/write/addr/wdata)
//               into AXI4-Lite write (AW/W/B) or read (AR/R) transactions.
//               One transaction outstanding; completion signalled by a
//               one-cycle done pulse carrying resp (and rdata for reads).
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_master_bridge #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   // CPU-side request / completion
   input  logic                  transfer,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  ready,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            resp,
   // AXI4-Lite master port
   axi4_lite_master_bridge_if.master m_axi
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WADDR = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t                state_q;
   logic                  ready_q;
   logic                  done_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            resp_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  bready_q;
   logic                  arvalid_q;
   logic                  rready_q;
   // Remember which write channel has already handshaken; AW and W finish
   // independently and in any order.
   logic                  aw_ok_q;
   logic                  w_ok_q;

   logic aw_hs;
   logic w_hs;
   logic aw_fin;
   logic w_fin;

   // Handshake detection on the write address / data channels
   always_comb begin
      aw_hs  = awvalid_q & m_axi.AWREADY;
      w_hs   = wvalid_q & m_axi.WREADY;
      aw_fin = aw_ok_q | aw_hs;
      w_fin  = w_ok_q | w_hs;
   end

   // Transaction FSM: every output is a register so the bus sees clean edges
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= 2'b00;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         araddr_q  <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         aw_ok_q   <= 1'b0;
         w_ok_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (transfer && ready_q) begin
                  ready_q <= 1'b0;
                  if (write) begin
                     awaddr_q  <= addr;
                     wdata_q   <= wdata;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_ok_q   <= 1'b0;
                     w_ok_q    <= 1'b0;
                     state_q   <= WADDR;
                  end else begin
                     araddr_q  <= addr;
                     arvalid_q <= 1'b1;
                     state_q   <= RADDR;
                  end
               end
            end
            WADDR: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_ok_q   <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_ok_q   <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  bready_q <= 1'b1;
                  state_q  <= WRESP;
               end
            end
            WRESP: begin
               if (m_axi.BVALID) begin
                  bready_q <= 1'b0;
                  resp_q   <= m_axi.BRESP;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            RADDR: begin
               if (m_axi.ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RDATA;
               end
            end
            RDATA: begin
               if (m_axi.RVALID) begin
                  rready_q <= 1'b0;
                  rdata_q  <= m_axi.RDATA;
                  resp_q   <= m_axi.RRESP;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q   <= 1'b1;
               awvalid_q <= 1'b0;
               wvalid_q  <= 1'b0;
               bready_q  <= 1'b0;
               arvalid_q <= 1'b0;
               rready_q  <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign ready         = ready_q;
   assign done          = done_q;
   assign rdata         = rdata_q;
   assign resp          = resp_q;
   assign m_axi.AWADDR  = awaddr_q;
   assign m_axi.AWVALID = awvalid_q;
   assign m_axi.WDATA   = wdata_q;
   assign m_axi.WVALID  = wvalid_q;
   assign m_axi.BREADY  = bready_q;
   assign m_axi.ARADDR  = araddr_q;
   assign m_axi.ARVALID = arvalid_q;
   assign m_axi.RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_master_bridge
// Description : Self-checking bench for axi4_lite_master_bridge. A slave
//               model with configurable per-channel wait states answers the
//               bus; a CPU-view word memory predicts read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master_bridge;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        transfer;
   logic        write;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic [31:0] rdata;
   logic [1:0]  resp;

   axi4_lite_master_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

   axi4_lite_master_bridge #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .ready    (ready),
      .done     (done),
      .rdata    (rdata),
      .resp     (resp),
      .m_axi    (bus)
   );

   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- slave model configuration (written by stimulus) -------
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int resp_mode = 0;   // <0: random response, else fixed code

   function automatic int pick(input int d);
      return (d < 0) ? int'($urandom_range(3, 0)) : d;
   endfunction

   function automatic logic [1:0] pick_resp();
      return (resp_mode < 0) ? 2'($urandom_range(3, 0)) : 2'(resp_mode);
   endfunction

   // ---------------- handshake monitor --------------------------------------
   int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
   logic [3:0]  aw_cap;
   logic [31:0] w_cap;
   logic [3:0]  ar_cap;

   always @(posedge ACLK) begin
      if (bus.AWVALID === 1'b1 && bus.AWREADY === 1'b1) begin aw_cap = bus.AWADDR; aw_hs_cnt++; end
      if (bus.WVALID === 1'b1 && bus.WREADY === 1'b1) begin w_cap = bus.WDATA; w_hs_cnt++; end
      if (bus.BVALID === 1'b1 && bus.BREADY === 1'b1) b_hs_cnt++;
      if (bus.ARVALID === 1'b1 && bus.ARREADY === 1'b1) begin ar_cap = bus.ARADDR; ar_hs_cnt++; end
      if (bus.RVALID === 1'b1 && bus.RREADY === 1'b1) r_hs_cnt++;
   end

   // ---------------- slave responder ----------------------------------------
   logic [31:0] slv_mem [4] = '{default: 32'h0};
   int aw_used = 0, w_used = 0, b_used = 0, ar_used = 0, r_used = 0;
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
   bit aw_arm = 0, w_arm = 0, ar_arm = 0, b_pend = 0, r_pend = 0;
   logic [3:0] r_addr = 4'h0;
   int writes_seen = 0;
   logic [1:0] last_resp = 2'b00;

   always @(negedge ACLK) begin
      if (ARESET) begin
         bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.ARREADY = 1'b0;
         bus.BVALID = 1'b0; bus.BRESP = 2'b00;
         bus.RVALID = 1'b0; bus.RDATA = 32'h0; bus.RRESP = 2'b00;
         aw_used = aw_hs_cnt; w_used = w_hs_cnt; b_used = b_hs_cnt;
         ar_used = ar_hs_cnt; r_used = r_hs_cnt;
         aw_arm = 0; w_arm = 0; ar_arm = 0; b_pend = 0; r_pend = 0;
      end else begin
         if (bus.AWREADY) begin bus.AWREADY = 1'b0; aw_arm = 0; end
         else if (bus.AWVALID) begin
            if (!aw_arm) begin aw_cnt = pick(aw_dly); aw_arm = 1; end
            if (aw_cnt == 0) bus.AWREADY = 1'b1; else aw_cnt--;
         end
         if (bus.WREADY) begin bus.WREADY = 1'b0; w_arm = 0; end
         else if (bus.WVALID) begin
            if (!w_arm) begin w_cnt = pick(w_dly); w_arm = 1; end
            if (w_cnt == 0) bus.WREADY = 1'b1; else w_cnt--;
         end
         if (bus.ARREADY) begin bus.ARREADY = 1'b0; ar_arm = 0; end
         else if (bus.ARVALID) begin
            if (!ar_arm) begin ar_cnt = pick(ar_dly); ar_arm = 1; end
            if (ar_cnt == 0) bus.ARREADY = 1'b1; else ar_cnt--;
         end
         // Commit a write once both address and data have arrived
         if (aw_hs_cnt > aw_used && w_hs_cnt > w_used) begin
            slv_mem[aw_cap[3:2]] = w_cap;
            aw_used++; w_used++; writes_seen++;
            b_pend = 1; b_cnt = pick(b_dly);
         end
         if (bus.BVALID) begin
            if (b_hs_cnt > b_used) begin bus.BVALID = 1'b0; b_used++; end
         end else if (b_pend) begin
            if (b_cnt == 0) begin
               bus.BVALID = 1'b1; bus.BRESP = pick_resp(); last_resp = bus.BRESP; b_pend = 0;
            end else b_cnt--;
         end
         if (ar_hs_cnt > ar_used) begin
            ar_used++; r_pend = 1; r_cnt = pick(r_dly); r_addr = ar_cap;
         end
         if (bus.RVALID) begin
            if (r_hs_cnt > r_used) begin bus.RVALID = 1'b0; r_used++; end
         end else if (r_pend) begin
            if (r_cnt == 0) begin
               bus.RVALID = 1'b1; bus.RDATA = slv_mem[r_addr[3:2]];
               bus.RRESP = pick_resp(); last_resp = bus.RRESP; r_pend = 0;
            end else r_cnt--;
         end
      end
   end

   // ---------------- CPU-view reference model -------------------------------
   logic [31:0] ref_mem [4] = '{default: 32'h0};
   logic [31:0] exp_rdata = 32'h0;

   // One CPU request: waits for ready, issues it, follows it to done and
   // compares the result with the reference model.
   task automatic run_xfer(input bit wr, input logic [3:0] a, input logic [31:0] d,
                           input int exp_lat, input bit pulse_busy,
                           output int aw_low, output int w_low);
      int guard = 0;
      int lat;
      int wr_before;
      aw_low = 0; w_low = 0;
      while (ready !== 1'b1 && guard < 200) begin @(negedge ACLK); guard++; end
      check("ready_wait_bound", (guard < 200), 1'b1);
      wr_before = writes_seen;
      transfer = 1'b1; write = wr; addr = a; wdata = d;
      @(posedge ACLK);
      @(negedge ACLK);
      transfer = pulse_busy; write = 1'b1; addr = 4'hC; wdata = $urandom;
      check("ready_low_busy", ready, 1'b0);
      lat = 1;
      while (lat < 200) begin
         if (wr && aw_low == 0 && bus.AWVALID === 1'b0) aw_low = lat;
         if (wr && w_low == 0 && bus.WVALID === 1'b0) w_low = lat;
         if (done === 1'b1) break;
         @(negedge ACLK);
         lat++;
         if (lat == 2) transfer = 1'b0;
      end
      check("done_seen_bound", (lat < 200), 1'b1);
      if (exp_lat >= 0) check("latency", lat, exp_lat);
      if (wr) ref_mem[a[3:2]] = d;
      else    exp_rdata = ref_mem[a[3:2]];
      check("ready_at_done", ready, 1'b0);
      check("resp", resp, last_resp);
      check("rdata", rdata, exp_rdata);
      if (wr) begin
         check("slave_word", slv_mem[a[3:2]], d);
         check("write_count", writes_seen, wr_before + 1);
      end else begin
         check("no_write_on_read", writes_seen, wr_before);
      end
      @(negedge ACLK);
      check("done_one_cycle", done, 1'b0);
      check("ready_after_done", ready, 1'b1);
   endtask

   initial begin
      int awl, wl;
      int aw_before;
      int guard;
      ARESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = 4'h0; wdata = 32'h0;
      repeat (3) @(negedge ACLK);
      // Reset state
      check("rst_ready", ready, 1'b1);
      check("rst_done", done, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_resp", resp, 2'b00);
      check("rst_awvalid", bus.AWVALID, 1'b0);
      check("rst_wvalid", bus.WVALID, 1'b0);
      check("rst_bready", bus.BREADY, 1'b0);
      check("rst_arvalid", bus.ARVALID, 1'b0);
      check("rst_rready", bus.RREADY, 1'b0);
      check("rst_awaddr", bus.AWADDR, 4'h0);
      check("rst_wdata", bus.WDATA, 32'h0);
      check("rst_araddr", bus.ARADDR, 4'h0);
      ARESET = 1'b0;
      @(negedge ACLK);

      // Zero-wait write of 0xFF to 0x0
      run_xfer(1'b1, 4'h0, 32'hFF, 3, 1'b0, awl, wl);
      // Back-to-back writes to 0x4
      run_xfer(1'b1, 4'h4, 32'hAA, 3, 1'b0, awl, wl);
      run_xfer(1'b1, 4'h4, 32'h55, 3, 1'b0, awl, wl);
      // Reads of 0x8 after loading it through the bridge
      run_xfer(1'b1, 4'h8, 32'h12, 3, 1'b0, awl, wl);
      run_xfer(1'b0, 4'h8, 32'h0, 3, 1'b0, awl, wl);
      run_xfer(1'b1, 4'h8, 32'h34, 3, 1'b0, awl, wl);
      run_xfer(1'b0, 4'h8, 32'h0, 3, 1'b0, awl, wl);

      // W channel late, then AW channel late
      aw_dly = 0; w_dly = 3;
      run_xfer(1'b1, 4'hC, 32'hCAFE0001, 6, 1'b0, awl, wl);
      check("aw_drop_early", awl, 2);
      check("w_drop_late", wl, 5);
      aw_dly = 3; w_dly = 0;
      run_xfer(1'b1, 4'hC, 32'hCAFE0002, 6, 1'b0, awl, wl);
      check("aw_drop_late", awl, 5);
      check("w_drop_early", wl, 2);
      aw_dly = 0; w_dly = 0;

      // Reset while waiting in the write-response phase
      b_dly = 30;
      transfer = 1'b1; write = 1'b1; addr = 4'h0; wdata = 32'hDEAD;
      @(posedge ACLK);
      @(negedge ACLK);
      transfer = 1'b0;
      guard = 0;
      while (bus.BREADY !== 1'b1 && guard < 20) begin @(negedge ACLK); guard++; end
      check("t5_bready_seen", bus.BREADY, 1'b1);
      ref_mem[0] = 32'hDEAD;
      @(posedge ACLK);
      #2 ARESET = 1'b1;
      #1;
      check("t5_bready_drop", bus.BREADY, 1'b0);
      check("t5_awvalid_drop", bus.AWVALID, 1'b0);
      check("t5_wvalid_drop", bus.WVALID, 1'b0);
      check("t5_ready", ready, 1'b1);
      check("t5_rdata_cleared", rdata, 32'h0);
      exp_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         check("t5_no_done", done, 1'b0);
      end
      ARESET = 1'b0;
      b_dly = 0;
      @(negedge ACLK);
      check("t5_no_done_after", done, 1'b0);
      check("t5_ready_after", ready, 1'b1);
      run_xfer(1'b0, 4'h8, 32'h0, 3, 1'b0, awl, wl);

      // Request pulsed while busy; slave answers SLVERR
      resp_mode = 2;
      aw_before = aw_hs_cnt;
      run_xfer(1'b0, 4'h4, 32'h0, 3, 1'b1, awl, wl);
      check("t6_resp", resp, 2'b10);
      for (int i = 0; i < 4; i++) begin
         @(negedge ACLK);
         check("t6_idle_ready", ready, 1'b1);
         check("t6_no_done", done, 1'b0);
      end
      check("t6_no_extra_aw", aw_hs_cnt, aw_before);

      // Randomized traffic with random wait states and responses
      aw_dly = -1; w_dly = -1; b_dly = -1; ar_dly = -1; r_dly = -1; resp_mode = -1;
      for (int i = 0; i < 30; i++) begin
         logic [3:0] ra;
         bit rw;
         rw = 1'($urandom_range(1, 0));
         ra = {2'($urandom_range(3, 0)), 2'b00};
         run_xfer(rw, ra, $urandom, -1, 1'b0, awl, wl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
